// File: rtl/fifo_bram_fwft.sv
// fifo_bram_fwft: first-word-fall-through FIFO built on a registered-read block RAM with a prefetch stage.
// Define FIFO_BRAM_ERRFLAG_EN to build the sticky overflow/underflow flags cleared by errclr.
module fifo_bram_fwft #(
    parameter int DATAWIDTH = 13,
    parameter int ADDRBIT   = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifowr,
    input  logic [DATAWIDTH-1:0] fifo_data_in,
    output logic                 fifofull,
    output logic                 almostfull,
    input  logic                 fiford,
    output logic [DATAWIDTH-1:0] fifo_data_out,
    output logic                 notempty,
    output logic                 almostempty,
    output logic [ADDRBIT:0]     fifolen,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 errclr
);

    localparam int               CAP      = 1 << ADDRBIT;
    localparam logic [ADDRBIT:0] CAP_L    = (ADDRBIT+1)'(CAP);
    localparam logic [ADDRBIT:0] AFULL_L  = (ADDRBIT+1)'(AFULL_TH);
    localparam logic [ADDRBIT:0] AEMPTY_L = (ADDRBIT+1)'(AEMPTY_TH);
    localparam logic [ADDRBIT:0] ONE_L    = (ADDRBIT+1)'(1);

    logic [DATAWIDTH-1:0] r_mem [0:CAP-1];
    logic [ADDRBIT:0]     r_wptr;
    logic [ADDRBIT:0]     r_rptr;
    logic [DATAWIDTH-1:0] r_ram_q;
    logic [DATAWIDTH-1:0] r_byp;
    logic                 r_q_byp;
    logic                 r_q_vld;
    logic [DATAWIDTH-1:0] r_dout;
    logic                 r_dout_vld;
    logic [ADDRBIT:0]     r_cnt;
    logic                 r_full;
    logic                 r_afull;
    logic                 r_aempty;

    logic                 w_push;
    logic                 w_pop;
    logic [ADDRBIT:0]     w_ram_cnt;
    logic                 w_ram_empty;
    logic                 w_out_take;
    logic                 w_q_free;
    logic                 w_q_to_out;
    logic                 w_in_to_out;
    logic                 w_in_to_q;
    logic                 w_wr_ram;
    logic                 w_rd;
    logic [DATAWIDTH-1:0] w_q_data;
    logic [ADDRBIT:0]     w_cnt_nxt;

    assign w_push      = fifowr & ~r_full & ~flush;
    assign w_pop       = fiford & r_dout_vld & ~flush;
    assign w_ram_cnt   = r_wptr - r_rptr;
    assign w_ram_empty = (w_ram_cnt == '0);

    // The middle stage holds either a RAM read result or a word bypassed from the input, so a fresh
    // push never waits a cycle in RAM while older data drains; that keeps pops gap-free.
    assign w_out_take  = ~r_dout_vld | w_pop;
    assign w_q_free    = ~r_q_vld | w_out_take;
    assign w_q_to_out  = r_q_vld & w_out_take & ~flush;
    assign w_in_to_out = w_push & w_out_take & ~r_q_vld & w_ram_empty;
    assign w_in_to_q   = w_push & ~w_in_to_out & w_ram_empty & w_q_free;
    assign w_wr_ram    = w_push & ~w_in_to_out & ~w_in_to_q;
    assign w_rd        = ~w_ram_empty & w_q_free & ~flush;
    assign w_q_data    = r_q_byp ? r_byp : r_ram_q;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (flush) begin
            w_cnt_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + ONE_L;
                2'b01:   w_cnt_nxt = r_cnt - ONE_L;
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_mem[r_wptr[ADDRBIT-1:0]] <= fifo_data_in;
        end
        if (w_rd) begin
            r_ram_q <= r_mem[r_rptr[ADDRBIT-1:0]];
        end
        if (w_in_to_q) begin
            r_byp <= fifo_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_q_vld    <= 1'b0;
            r_q_byp    <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            if (flush) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_q_vld    <= 1'b0;
                r_dout_vld <= 1'b0;
            end else begin
                if (w_wr_ram) begin
                    r_wptr <= r_wptr + ONE_L;
                end
                if (w_rd) begin
                    r_rptr <= r_rptr + ONE_L;
                end
                if (w_rd | w_in_to_q) begin
                    r_q_vld <= 1'b1;
                    r_q_byp <= w_in_to_q;
                end else if (w_q_to_out) begin
                    r_q_vld <= 1'b0;
                end
                if (w_q_to_out) begin
                    r_dout     <= w_q_data;
                    r_dout_vld <= 1'b1;
                end else if (w_in_to_out) begin
                    r_dout     <= fifo_data_in;
                    r_dout_vld <= 1'b1;
                end else if (w_pop) begin
                    r_dout_vld <= 1'b0;
                end
            end
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CAP_L);
            r_afull  <= (w_cnt_nxt >= AFULL_L);
            r_aempty <= (w_cnt_nxt <= AEMPTY_L);
        end
    end

    assign fifofull      = r_full;
    assign almostfull    = r_afull;
    assign almostempty   = r_aempty;
    assign notempty      = r_dout_vld;
    assign fifo_data_out = r_dout;
    assign fifolen       = r_cnt;

`ifdef FIFO_BRAM_ERRFLAG_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = fifowr & r_full & ~flush;
    assign w_unf_set = fiford & ~r_dout_vld & ~flush;

    // A same-cycle error event wins over errclr so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (errclr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (errclr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;
`else
    logic w_unused_errclr;
    assign w_unused_errclr = errclr;
    assign overflow        = 1'b0;
    assign underflow       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_bram_fwft.sv
// tb_fifo_bram_fwft: scoreboard bench for fifo_bram_fwft, one stimulus step per clock.
module tb_fifo_bram_fwft;

    localparam int DW  = 13;
    localparam int AB  = 4;
    localparam int CAP = 16;
    localparam int AF  = 12;
    localparam int AE  = 2;
`ifdef FIFO_BRAM_ERRFLAG_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fifowr;
    logic [DW-1:0] fifo_data_in;
    logic          fifofull;
    logic          almostfull;
    logic          fiford;
    logic [DW-1:0] fifo_data_out;
    logic          notempty;
    logic          almostempty;
    logic [AB:0]   fifolen;
    logic          overflow;
    logic          underflow;
    logic          errclr;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb[$];
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    fifo_bram_fwft #(
        .DATAWIDTH(DW),
        .ADDRBIT  (AB),
        .AFULL_TH (AF),
        .AEMPTY_TH(AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fifowr       (fifowr),
        .fifo_data_in (fifo_data_in),
        .fifofull     (fifofull),
        .almostfull   (almostfull),
        .fiford       (fiford),
        .fifo_data_out(fifo_data_out),
        .notempty     (notempty),
        .almostempty  (almostempty),
        .fifolen      (fifolen),
        .overflow     (overflow),
        .underflow    (underflow),
        .errclr       (errclr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, ":len"},    32'(fifolen),     32'(sz));
        chk({tag, ":ne"},     32'(notempty),    32'(sz > 0));
        chk({tag, ":full"},   32'(fifofull),    32'(sz == CAP));
        chk({tag, ":afull"},  32'(almostfull),  32'(sz >= AF));
        chk({tag, ":aempty"}, 32'(almostempty), 32'(sz <= AE));
        chk({tag, ":ovf"},    32'(overflow),    32'(FLAGS & ovf_m));
        chk({tag, ":unf"},    32'(underflow),   32'(FLAGS & unf_m));
        if (sz > 0) begin
            chk({tag, ":head"}, 32'(fifo_data_out), 32'(sb[0]));
        end
    endtask

    // Called just after a falling edge: drive, update the model, cross the rising edge, then check.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic fl, input logic ec, input logic rs, input string tag);
        int   sz;
        logic set_o;
        logic set_u;
        fifowr       = wr;
        fifo_data_in = d;
        fiford       = rd;
        flush        = fl;
        errclr       = ec;
        rst          = rs;
        sz           = sb.size();
        set_o        = wr && (sz == CAP) && !fl;
        set_u        = rd && (sz == 0) && !fl;
        if (rs) begin
            sb.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            if (fl) begin
                sb.delete();
            end else begin
                if (rd && sz > 0) begin
                    chk({tag, ":pop"}, 32'(fifo_data_out), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                if (wr && sz < CAP) begin
                    sb.push_back(d);
                end
            end
            ovf_m = set_o ? 1'b1 : (ec ? 1'b0 : ovf_m);
            unf_m = set_u ? 1'b1 : (ec ? 1'b0 : unf_m);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic push(input logic [DW-1:0] d, input string tag);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic pop(input string tag);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; fifowr = 1'b0; fiford = 1'b0; errclr = 1'b0;
        fifo_data_in = '0;
        @(negedge clk);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
        chk("reset:dout", 32'(fifo_data_out), 32'h0);

        // Single push into an empty FIFO falls through in one cycle.
        push(13'h001, "first");
        pop("first_pop");

        // Fill to full, then a dropped push with a read also requested while full is tested later.
        for (int i = 0; i < CAP; i++) push(DW'(i), "fill");
        push(13'h1FF, "drop");
        step(1'b1, 13'h1FE, 1'b0, 1'b0, 1'b1, 1'b0, "drop_clr");

        for (int i = 0; i < CAP; i++) pop("drain");
        pop("under");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "errclr");

        // Steady push+pop across pointer wrap.
        for (int i = 0; i < 8; i++) push(DW'(12'h080 + i), "fill8");
        for (int i = 0; i < 40; i++) step(1'b1, DW'(12'h100 + i), 1'b1, 1'b0, 1'b0, 1'b0, "stream");
        for (int i = 0; i < 16; i++) push(DW'(12'h200 + i), "refill");
        step(1'b1, 13'h0055, 1'b1, 1'b0, 1'b0, 1'b0, "full_rdwr");
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "flush0");

        // Flush overrides a same-cycle push.
        for (int i = 0; i < 5; i++) push(DW'(12'h300 + i), "fill5");
        step(1'b1, 13'h0777, 1'b1, 1'b1, 1'b0, 1'b0, "flush_wr");
        push(13'h0123, "post_flush");
        pop("post_flush_pop");

        // Reset with entries and a RAM read in flight.
        for (int i = 0; i < 10; i++) push(DW'(12'h400 + i), "fill10");
        step(1'b1, 13'h0155, 1'b1, 1'b0, 1'b0, 1'b1, "rst_mid");
        chk("rst_mid:dout", 32'(fifo_data_out), 32'h0);
        push(13'h00AA, "after_rst");
        pop("after_rst_pop");

        for (int i = 0; i < 400; i++) begin
            step(1'b0 + ($urandom_range(0, 99) < 55), DW'($urandom),
                 1'b0 + ($urandom_range(0, 99) < 50),
                 1'b0 + ($urandom_range(0, 59) == 0),
                 1'b0 + ($urandom_range(0, 19) == 0), 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
